// File: rtl/asc_pkg.sv
// rtl/asc_pkg.sv - shared encodings for the add/sub/compare arbiter
package asc_pkg;

    localparam logic [1:0] ASC_OP_ADD = 2'b00;
    localparam logic [1:0] ASC_OP_SUB = 2'b01;
    localparam logic [1:0] ASC_OP_SLT = 2'b10;
    localparam logic [1:0] ASC_OP_SEQ = 2'b11;

    localparam logic ASC_REQ0 = 1'b0;
    localparam logic ASC_REQ1 = 1'b1;

    typedef enum logic {
        ASC_EMPTY = 1'b0,
        ASC_FULL  = 1'b1
    } asc_state_e;

endpackage

// File: rtl/addSubComp.sv
// rtl/addSubComp.sv - signed add, subtract and compare datapath with overflow flags
module addSubComp #(
    parameter int NUM_SIZE = 32
) (
    input  logic [NUM_SIZE-1:0] a,
    input  logic [NUM_SIZE-1:0] b,
    output logic [NUM_SIZE-1:0] add,
    output logic [NUM_SIZE-1:0] sub,
    output logic                overflowAdd,
    output logic                overflowSub,
    output logic                equal,
    output logic                greaterThan,
    output logic                lessThan
);

    // Two's complement overflow: the result sign disagrees with what the operand signs force.
    always_comb begin
        add         = a + b;
        sub         = a - b;
        overflowAdd = (a[NUM_SIZE-1] == b[NUM_SIZE-1]) && (add[NUM_SIZE-1] != a[NUM_SIZE-1]);
        overflowSub = (a[NUM_SIZE-1] != b[NUM_SIZE-1]) && (sub[NUM_SIZE-1] != a[NUM_SIZE-1]);
        equal       = (a == b);
        lessThan    = ($signed(a) < $signed(b));
        greaterThan = ($signed(a) > $signed(b));
    end

endmodule

// File: rtl/asc_arbiter_rr_arb2.sv
// rtl/asc_arbiter_rr_arb2.sv - two-way round-robin grant with last-grant memory
module rr_arb2
    import asc_pkg::*;
(
    input  logic clk,
    input  logic rstN,
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic advance_i,
    output logic grant_o
);

    logic last_grant_q;

    // A lone requester always wins; on a tie the one not served last time wins.
    always_comb begin
        if (valid0_i && valid1_i) begin
            grant_o = ~last_grant_q;
        end else begin
            grant_o = valid1_i ? ASC_REQ1 : ASC_REQ0;
        end
    end

    // Remember the winner only when the grant was actually consumed; reset favours req0 first.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            last_grant_q <= ASC_REQ1;
        end else if (advance_i) begin
            last_grant_q <= grant_o;
        end
    end

endmodule

// File: rtl/asc_arbiter.sv
// rtl/asc_arbiter.sv - shares one addSubComp between two requesters (optional ASC_GRANT_CNT_EN counters)
module asc_arbiter
    import asc_pkg::*;
#(
    parameter int NUM_SIZE = 32,
    parameter int TAG_W    = 4
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                req0Valid,
    output logic                req0Ready,
    input  logic [1:0]          req0Op,
    input  logic [NUM_SIZE-1:0] req0A,
    input  logic [NUM_SIZE-1:0] req0B,
    input  logic [TAG_W-1:0]    req0Tag,
    input  logic                req1Valid,
    output logic                req1Ready,
    input  logic [1:0]          req1Op,
    input  logic [NUM_SIZE-1:0] req1A,
    input  logic [NUM_SIZE-1:0] req1B,
    input  logic [TAG_W-1:0]    req1Tag,
`ifdef ASC_GRANT_CNT_EN
    output logic [31:0]         grantCnt0,
    output logic [31:0]         grantCnt1,
`endif
    output logic                rspValid,
    input  logic                rspReady,
    output logic                rspReqId,
    output logic [TAG_W-1:0]    rspTag,
    output logic [NUM_SIZE-1:0] rspResult,
    output logic                rspOverflow,
    output logic                rspEqual,
    output logic                rspGreaterThan,
    output logic                rspLessThan
);

    asc_state_e          state_q;
    logic                rsp_valid_q;
    logic                rsp_req_id_q;
    logic [TAG_W-1:0]    rsp_tag_q;
    logic [NUM_SIZE-1:0] rsp_result_q;
    logic                rsp_ovf_q, rsp_eq_q, rsp_gt_q, rsp_lt_q;

    logic                grant;
    logic                can_accept, accept;
    logic [1:0]          op_mux;
    logic [NUM_SIZE-1:0] a_mux, b_mux;
    logic [TAG_W-1:0]    tag_mux;
    logic [NUM_SIZE-1:0] add_res, sub_res;
    logic                ovf_add, ovf_sub, eq_flag, gt_flag, lt_flag;
    logic [NUM_SIZE-1:0] result_d;
    logic                ovf_d;

    // Buffer slot is free when empty, or when the held response leaves this same cycle.
    assign can_accept = (state_q == ASC_EMPTY) || (rsp_valid_q && rspReady);
    assign accept     = can_accept && (req0Valid || req1Valid);
    assign req0Ready  = accept && (grant == ASC_REQ0);
    assign req1Ready  = accept && (grant == ASC_REQ1);

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rstN      (rstN),
        .valid0_i  (req0Valid),
        .valid1_i  (req1Valid),
        .advance_i (accept),
        .grant_o   (grant)
    );

    // Steer the granted requester's operation into the shared datapath.
    always_comb begin
        if (grant == ASC_REQ1) begin
            op_mux  = req1Op;
            a_mux   = req1A;
            b_mux   = req1B;
            tag_mux = req1Tag;
        end else begin
            op_mux  = req0Op;
            a_mux   = req0A;
            b_mux   = req0B;
            tag_mux = req0Tag;
        end
    end

    addSubComp #(.NUM_SIZE(NUM_SIZE)) u_add_sub_comp (
        .a           (a_mux),
        .b           (b_mux),
        .add         (add_res),
        .sub         (sub_res),
        .overflowAdd (ovf_add),
        .overflowSub (ovf_sub),
        .equal       (eq_flag),
        .greaterThan (gt_flag),
        .lessThan    (lt_flag)
    );

    // Pick the result for the op; compares ride on the subtractor, so they report its overflow.
    always_comb begin
        ovf_d = (op_mux == ASC_OP_ADD) ? ovf_add : ovf_sub;
        case (op_mux)
            ASC_OP_ADD: result_d = add_res;
            ASC_OP_SUB: result_d = sub_res;
            ASC_OP_SLT: result_d = {{(NUM_SIZE-1){1'b0}}, lt_flag};
            default:    result_d = {{(NUM_SIZE-1){1'b0}}, eq_flag};
        endcase
    end

    // One-entry response buffer FSM; data only loads on accept and otherwise holds.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q      <= ASC_EMPTY;
            rsp_valid_q  <= 1'b0;
            rsp_req_id_q <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_result_q <= '0;
            rsp_ovf_q    <= 1'b0;
            rsp_eq_q     <= 1'b0;
            rsp_gt_q     <= 1'b0;
            rsp_lt_q     <= 1'b0;
        end else begin
            if (accept) begin
                rsp_req_id_q <= grant;
                rsp_tag_q    <= tag_mux;
                rsp_result_q <= result_d;
                rsp_ovf_q    <= ovf_d;
                rsp_eq_q     <= eq_flag;
                rsp_gt_q     <= gt_flag;
                rsp_lt_q     <= lt_flag;
            end
            case (state_q)
                ASC_EMPTY: begin
                    if (accept) begin
                        state_q     <= ASC_FULL;
                        rsp_valid_q <= 1'b1;
                    end
                end
                default: begin
                    if (!accept && rspReady) begin
                        state_q     <= ASC_EMPTY;
                        rsp_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign rspValid       = rsp_valid_q;
    assign rspReqId       = rsp_req_id_q;
    assign rspTag         = rsp_tag_q;
    assign rspResult      = rsp_result_q;
    assign rspOverflow    = rsp_ovf_q;
    assign rspEqual       = rsp_eq_q;
    assign rspGreaterThan = rsp_gt_q;
    assign rspLessThan    = rsp_lt_q;

`ifdef ASC_GRANT_CNT_EN
    logic [31:0] grant_cnt0_q, grant_cnt1_q;

    // Per-requester accept counters, free-running with natural wrap.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
        end else begin
            if (req0Ready) grant_cnt0_q <= grant_cnt0_q + 32'd1;
            if (req1Ready) grant_cnt1_q <= grant_cnt1_q + 32'd1;
        end
    end

    assign grantCnt0 = grant_cnt0_q;
    assign grantCnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_asc_arbiter.sv
// tb/tb_asc_arbiter.sv - self-checking bench for asc_arbiter
module tb_asc_arbiter;

    logic        clk;
    logic        rstN;
    logic        req0Valid, req1Valid, req0Ready, req1Ready;
    logic [1:0]  req0Op, req1Op;
    logic [31:0] req0A, req0B, req1A, req1B;
    logic [3:0]  req0Tag, req1Tag;
    logic        rspValid, rspReady, rspReqId;
    logic [3:0]  rspTag;
    logic [31:0] rspResult;
    logic        rspOverflow, rspEqual, rspGreaterThan, rspLessThan;
`ifdef ASC_GRANT_CNT_EN
    logic [31:0] grantCnt0, grantCnt1;
`endif

    int errors = 0;
    int checks = 0;

    asc_arbiter #(.NUM_SIZE(32), .TAG_W(4)) dut (
        .clk            (clk),
        .rstN           (rstN),
        .req0Valid      (req0Valid),
        .req0Ready      (req0Ready),
        .req0Op         (req0Op),
        .req0A          (req0A),
        .req0B          (req0B),
        .req0Tag        (req0Tag),
        .req1Valid      (req1Valid),
        .req1Ready      (req1Ready),
        .req1Op         (req1Op),
        .req1A          (req1A),
        .req1B          (req1B),
        .req1Tag        (req1Tag),
`ifdef ASC_GRANT_CNT_EN
        .grantCnt0      (grantCnt0),
        .grantCnt1      (grantCnt1),
`endif
        .rspValid       (rspValid),
        .rspReady       (rspReady),
        .rspReqId       (rspReqId),
        .rspTag         (rspTag),
        .rspResult      (rspResult),
        .rspOverflow    (rspOverflow),
        .rspEqual       (rspEqual),
        .rspGreaterThan (rspGreaterThan),
        .rspLessThan    (rspLessThan)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference semantics: signed arithmetic in 64 bits, overflow when the true value leaves 32-bit range.
    function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] res, output bit ovf,
                                   output bit eq, output bit gt, output bit lt);
        longint sa, sb, s, d;
        bit oa, os;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = sa + sb;
        d  = sa - sb;
        oa = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        os = (d > 64'sd2147483647) || (d < -64'sd2147483648);
        eq = (sa == sb);
        gt = (sa > sb);
        lt = (sa < sb);
        ovf = (op == 2'd0) ? oa : os;
        case (op)
            2'd0:    res = 32'(s);
            2'd1:    res = 32'(d);
            2'd2:    res = lt ? 32'd1 : 32'd0;
            default: res = eq ? 32'd1 : 32'd0;
        endcase
    endfunction

    // Model state: whether a response is buffered, who was served last, and what the buffer holds.
    bit          m_full, m_last, m_id, m_ovf, m_eq, m_gt, m_lt;
    logic [31:0] m_res;
    logic [3:0]  m_tag;
    int unsigned m_cnt0, m_cnt1;
    bit          c_can, c_any, c_g, c_acc;

    always @(negedge clk) begin
        if (!rstN) begin
            m_full = 0; m_last = 1; m_id = 0; m_ovf = 0; m_eq = 0; m_gt = 0; m_lt = 0;
            m_res = '0; m_tag = '0; m_cnt0 = 0; m_cnt1 = 0;
        end else begin
            c_can = !m_full || rspReady;
            c_any = req0Valid || req1Valid;
            c_g   = (req0Valid && req1Valid) ? !m_last : req1Valid;
            c_acc = c_can && c_any;
            chk("req0Ready", 64'(req0Ready), 64'(c_acc && !c_g));
            chk("req1Ready", 64'(req1Ready), 64'(c_acc && c_g));
            chk("rspValid", 64'(rspValid), 64'(m_full));
            chk("rspReqId", 64'(rspReqId), 64'(m_id));
            chk("rspTag", 64'(rspTag), 64'(m_tag));
            chk("rspResult", 64'(rspResult), 64'(m_res));
            chk("rspOverflow", 64'(rspOverflow), 64'(m_ovf));
            chk("rspFlags", 64'({rspEqual, rspGreaterThan, rspLessThan}), 64'({m_eq, m_gt, m_lt}));
`ifdef ASC_GRANT_CNT_EN
            chk("grantCnt0", 64'(grantCnt0), 64'(m_cnt0));
            chk("grantCnt1", 64'(grantCnt1), 64'(m_cnt1));
`endif
            if (c_acc) begin
                m_last = c_g;
                m_full = 1;
                m_id   = c_g;
                if (c_g) begin
                    ref_op(req1Op, req1A, req1B, m_res, m_ovf, m_eq, m_gt, m_lt);
                    m_tag = req1Tag;
                    m_cnt1++;
                end else begin
                    ref_op(req0Op, req0A, req0B, m_res, m_ovf, m_eq, m_gt, m_lt);
                    m_tag = req0Tag;
                    m_cnt0++;
                end
            end else if (m_full && rspReady) begin
                m_full = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstN = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    task automatic set_req(input int idx, input logic v, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        if (idx == 0) begin
            req0Valid = v; req0Op = op; req0A = a; req0B = b; req0Tag = tag;
        end else begin
            req1Valid = v; req1Op = op; req1A = a; req1B = b; req1Tag = tag;
        end
    endtask

    logic [1:0]  v_op  [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [31:0] v_a   [4] = '{32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFD, 32'd9};
    logic [31:0] v_b   [4] = '{32'd1, 32'd7, 32'd2, 32'd9};
    logic [31:0] v_res [4] = '{32'h8000_0000, 32'hFFFF_FFFE, 32'd1, 32'd1};
    logic        v_ovf [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic        alt   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        rspReady = 1'b0;
        set_req(0, 1'b0, 2'd0, 32'd0, 32'd0, 4'd0);
        set_req(1, 1'b0, 2'd0, 32'd0, 32'd0, 4'd0);
        rstN = 1'b0;
        @(negedge clk);
        #2;
        chk("reset rspValid", 64'(rspValid), 64'd0);
        chk("reset rspResult", 64'(rspResult), 64'd0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        tick();

        // Op decode on req0, one op per clock.
        rspReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1'b1, v_op[i], v_a[i], v_b[i], 4'(i));
            tick();
            chk("op result", 64'(rspResult), 64'(v_res[i]));
            chk("op overflow", 64'(rspOverflow), 64'(v_ovf[i]));
            chk("op tag", 64'(rspTag), 64'(i));
        end
        set_req(0, 1'b0, 2'd0, 32'd0, 32'd0, 4'd0);
        tick();
        chk("idle drain rspValid", 64'(rspValid), 64'd0);
        chk("idle drain data holds", 64'(rspResult), 64'd1);

        // Single requester on req1.
        set_req(1, 1'b1, 2'd0, 32'd3, 32'd4, 4'hA);
        #1;
        chk("single req1Ready", 64'(req1Ready), 64'd1);
        tick();
        chk("single rspReqId", 64'(rspReqId), 64'd1);
        chk("single rspTag", 64'(rspTag), 64'hA);
        chk("single rspResult", 64'(rspResult), 64'd7);

        // Tie after a req1 grant goes to req0, then alternates.
        set_req(0, 1'b1, 2'd1, 32'd10, 32'd3, 4'h1);
        set_req(1, 1'b1, 2'd0, 32'd20, 32'd4, 4'hB);
        #1;
        chk("tie req0Ready", 64'(req0Ready), 64'd1);
        tick();
        chk("tie first id", 64'(rspReqId), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("alt id", 64'(rspReqId), 64'(alt[i]));
            chk("alt valid", 64'(rspValid), 64'd1);
            chk("alt result", 64'(rspResult), alt[i] ? 64'd24 : 64'd7);
        end

        // Backpressure: buffer holds req0's SUB result while both requesters wait.
        rspReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp req0Ready", 64'(req0Ready), 64'd0);
            chk("bp req1Ready", 64'(req1Ready), 64'd0);
            chk("bp rspResult", 64'(rspResult), 64'd7);
            chk("bp rspTag", 64'(rspTag), 64'h1);
        end
        rspReady = 1'b1;
        #1;
        chk("bp release req1Ready", 64'(req1Ready), 64'd1);
        tick();
        chk("bp release id", 64'(rspReqId), 64'd1);
        chk("bp release result", 64'(rspResult), 64'd24);

        // Reset while FULL clears the buffer asynchronously.
        rspReady = 1'b0;
        #5;
        rstN = 1'b0;
        #1;
        chk("async reset rspValid", 64'(rspValid), 64'd0);
        chk("async reset rspTag", 64'(rspTag), 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        rspReady = 1'b1;
        tick();
        chk("post-reset tie id", 64'(rspReqId), 64'd0);
        chk("post-reset tie result", 64'(rspResult), 64'd7);

`ifdef ASC_GRANT_CNT_EN
        set_req(1, 1'b0, 2'd0, 32'd0, 32'd0, 4'd0);
        do_reset();
        rspReady = 1'b1;
        set_req(0, 1'b1, 2'd0, 32'd1, 32'd1, 4'd2);
        repeat (5) tick();
        set_req(0, 1'b0, 2'd0, 32'd0, 32'd0, 4'd0);
        set_req(1, 1'b1, 2'd0, 32'd2, 32'd2, 4'd3);
        repeat (3) tick();
        set_req(1, 1'b0, 2'd0, 32'd0, 32'd0, 4'd0);
        tick();
        chk("grantCnt0 literal", 64'(grantCnt0), 64'd5);
        chk("grantCnt1 literal", 64'(grantCnt1), 64'd3);
`endif

        set_req(0, 1'b0, 2'd0, 32'd0, 32'd0, 4'd0);
        set_req(1, 1'b0, 2'd0, 32'd0, 32'd0, 4'd0);
        repeat (2) tick();
        chk("final idle rspValid", 64'(rspValid), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
